// File: rtl/ad7606_multi_reader.sv
// ad7606_multi_reader
// Paces conversions for N_ADC AD7606 devices that share one 16-bit data bus
// and one RD strobe. After BUSY falls it reads every device in turn, one
// chip select at a time, and streams a framed record into a FIFO write port:
// one header word {HDR_TAG, frame_cnt[7:0]} followed by N_ADC*CHANNELS samples
// in order dev0 ch0..ch(CHANNELS-1), dev1 ..., and so on.
//
// Ports
//   clk_i, reset_i           clock, asynchronous active-high reset
//   en_i                     run enable, sampled at the conversion-period tick
//   conv_clk_o               CONVST to all devices (idle high, low pulse starts)
//   busy_i                   wired-OR BUSY, asynchronous to clk_i
//   rd_o, cs_o[N_ADC-1:0]    shared RD and per-device CS, active low
//   db_i[15:0]               shared data bus
//   fifo_data_o, fifo_wr_en_o, fifo_full_i   FIFO write port
//   frame_cnt_o              completed frames (wraps)
//   drop_cnt_o               dropped words + skipped frames (saturates)
//   err_cnt_o                BUSY timeouts + period overruns (saturates)
module ad7606_multi_reader #(
    parameter int         N_ADC        = 2,
    parameter int         CHANNELS     = 8,
    parameter int         CONV_PERIOD  = 1000,
    parameter int         CONV_LOW     = 4,
    parameter int         RD_LOW       = 3,
    parameter int         RD_HIGH      = 2,
    parameter int         BUSY_TIMEOUT = 800,
    parameter logic [7:0] HDR_TAG      = 8'hA5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    output logic             conv_clk_o,
    input  logic             busy_i,
    output logic             rd_o,
    output logic [N_ADC-1:0] cs_o,
    input  logic [15:0]      db_i,
    output logic [15:0]      fifo_data_o,
    output logic             fifo_wr_en_o,
    input  logic             fifo_full_i,
    output logic [15:0]      frame_cnt_o,
    output logic [15:0]      drop_cnt_o,
    output logic [7:0]       err_cnt_o
);
    localparam int DW   = (N_ADC > 1) ? $clog2(N_ADC) : 1;
    localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW   = $clog2(CONV_PERIOD);
    localparam int TOW  = $clog2(BUSY_TIMEOUT + 1);
    localparam int TMAX = (CONV_LOW > RD_LOW) ? ((CONV_LOW > RD_HIGH) ? CONV_LOW : RD_HIGH)
                                              : ((RD_LOW > RD_HIGH) ? RD_LOW : RD_HIGH);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CONV  = 4'd1;
    localparam logic [3:0] S_WRISE = 4'd2;
    localparam logic [3:0] S_WFALL = 4'd3;
    localparam logic [3:0] S_HDR   = 4'd4;
    localparam logic [3:0] S_SETUP = 4'd5;  // CS low, RD high: setup before first RD fall
    localparam logic [3:0] S_RDL   = 4'd6;
    localparam logic [3:0] S_RDH   = 4'd7;
    localparam logic [3:0] S_HOLD  = 4'd8;  // RD high, CS still low: hold after last RD rise

    logic [3:0]    state, state_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [TOW-1:0] to_cnt;
    logic [PW-1:0] per_cnt;
    logic [DW-1:0] dev, dev_n;
    logic [CW-1:0] ch, ch_n;
    logic [1:0]    busy_pipe;
    logic          busy_s, tick, to_hit, overrun;
    logic          cap, hdr_ld, timeout, hdr_skip, fr_done, wr_req, rd_win;
    logic [1:0]    err_inc;

    assign busy_s  = busy_pipe[1];
    assign tick    = en_i && (per_cnt == '0);
    assign to_hit  = (to_cnt == TOW'(BUSY_TIMEOUT - 1));
    assign overrun = tick && (state != S_IDLE);
    assign err_inc = {1'b0, timeout} + {1'b0, overrun};
    assign rd_win  = (state_n == S_SETUP) || (state_n == S_RDL) ||
                     (state_n == S_RDH) || (state_n == S_HOLD);

    // FIFO strobe is qualified by the full flag in the write cycle itself, so a
    // word is either written or counted as dropped, never both.
    assign fifo_wr_en_o = ((state == S_HDR) || wr_req) && !fifo_full_i;

    always_comb begin
        state_n  = state;
        tmr_n    = tmr + TW'(1);
        dev_n    = dev;
        ch_n     = ch;
        cap      = 1'b0;
        hdr_ld   = 1'b0;
        timeout  = 1'b0;
        hdr_skip = 1'b0;
        fr_done  = 1'b0;
        case (state)
            S_IDLE: begin
                tmr_n = '0;
                if (tick) state_n = S_CONV;
            end
            S_CONV:
                if (tmr == TW'(CONV_LOW - 1)) state_n = S_WRISE;
            S_WRISE:
                if (to_hit) begin
                    timeout = 1'b1;
                    state_n = S_IDLE;
                end else if (busy_s) state_n = S_WFALL;
            S_WFALL:
                if (to_hit) begin
                    timeout = 1'b1;
                    state_n = S_IDLE;
                end else if (!busy_s) begin
                    hdr_ld  = 1'b1;
                    state_n = S_HDR;
                end
            S_HDR:
                if (fifo_full_i) begin
                    hdr_skip = 1'b1;
                    state_n  = S_IDLE;
                end else begin
                    dev_n   = '0;
                    ch_n    = '0;
                    state_n = S_SETUP;
                end
            S_SETUP: begin
                tmr_n   = '0;
                state_n = S_RDL;
            end
            S_RDL:
                if (tmr == TW'(RD_LOW - 1)) begin
                    cap     = 1'b1;
                    tmr_n   = '0;
                    state_n = (ch == CW'(CHANNELS - 1)) ? S_HOLD : S_RDH;
                end
            S_RDH:
                if (tmr == TW'(RD_HIGH - 1)) begin
                    tmr_n   = '0;
                    ch_n    = ch + CW'(1);
                    state_n = S_RDL;
                end
            S_HOLD:
                if (dev == DW'(N_ADC - 1)) begin
                    fr_done = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    dev_n   = dev + DW'(1);
                    ch_n    = '0;
                    state_n = S_SETUP;
                end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= S_IDLE;
            tmr         <= '0;
            to_cnt      <= '0;
            per_cnt     <= '0;
            dev         <= '0;
            ch          <= '0;
            busy_pipe   <= '0;
            wr_req      <= 1'b0;
            conv_clk_o  <= 1'b1;
            rd_o        <= 1'b1;
            cs_o        <= '1;
            fifo_data_o <= '0;
            frame_cnt_o <= '0;
            drop_cnt_o  <= '0;
            err_cnt_o   <= '0;
        end else begin
            busy_pipe <= {busy_pipe[0], busy_i};
            state     <= state_n;
            tmr       <= tmr_n;
            dev       <= dev_n;
            ch        <= ch_n;
            wr_req    <= cap;

            if (!en_i || per_cnt == PW'(CONV_PERIOD - 1)) per_cnt <= '0;
            else                                          per_cnt <= per_cnt + PW'(1);

            // Timeout window opens at CONV entry and spans the BUSY waits.
            if (state == S_IDLE) to_cnt <= '0;
            else if (state == S_CONV || state == S_WRISE || state == S_WFALL)
                to_cnt <= to_cnt + TOW'(1);

            // Pin outputs are registered from the next state so they change
            // cleanly on the clock edge together with the FSM.
            conv_clk_o <= (state_n != S_CONV);
            rd_o       <= (state_n != S_RDL);
            cs_o       <= rd_win ? ~(N_ADC'(1) << dev_n) : '1;

            if (hdr_ld)   fifo_data_o <= {HDR_TAG, frame_cnt_o[7:0]};
            else if (cap) fifo_data_o <= db_i;

            if (fr_done) frame_cnt_o <= frame_cnt_o + 16'd1;

            if ((hdr_skip || (wr_req && fifo_full_i)) && drop_cnt_o != 16'hFFFF)
                drop_cnt_o <= drop_cnt_o + 16'd1;

            if (err_inc != 2'd0)
                err_cnt_o <= (err_cnt_o > (8'hFF - {6'd0, err_inc})) ? 8'hFF
                                                                     : err_cnt_o + {6'd0, err_inc};
        end
    end
endmodule

// File: doc/ad7606_multi_reader.md
Name: ad7606_multi_reader

Overview:
Parametrised successor to the single-device AD7606 packetizer. Drives CONVST for N_ADC AD7606 devices sharing one parallel 16-bit bus and one RD line, sequences per-device chip-select readout after BUSY falls, and streams framed samples (header + data) into a downstream FIFO write port. Sits between the ADC pins and the USB/MCU FIFO at the top level, clocked from the DCM fast clock.

Parameters:
N_ADC, 2, number of AD7606 devices (1..8), one cs_o bit each
CHANNELS, 8, words read per device per conversion (1..8)
CONV_PERIOD, 1000, clk_i cycles between CONVST starts (>= 64)
CONV_LOW, 4, cycles conv_clk_o held low per conversion start
RD_LOW, 3, cycles rd_o low per word
RD_HIGH, 2, cycles rd_o high between words
BUSY_TIMEOUT, 800, max cycles from CONVST to BUSY fall before abort
HDR_TAG, 8'hA5, upper byte of header word

Ports:
clk_i  input  1  system clock
reset_i  input  1  asynchronous, active-high reset
en_i  input  1  run enable; sampled at period boundary
conv_clk_o  output  1  CONVST A/B to all devices; idle high, low pulse starts conversion
busy_i  input  1  wired-OR BUSY from devices, asynchronous
rd_o  output  1  shared RD, active low
cs_o  output  N_ADC  per-device chip select, active low, at most one low
db_i  input  16  shared ADC data bus
fifo_data_o  output  16  word to FIFO
fifo_wr_en_o  output  1  one-cycle write strobe
fifo_full_i  input  1  FIFO full
frame_cnt_o  output  16  completed frames, wraps
drop_cnt_o  output  16  dropped words + skipped frames, saturates at 16'hFFFF
err_cnt_o  output  8  BUSY timeouts + period overruns, saturates at 8'hFF

Behaviour:
- Reset (async assert, sync deassert by clk_i): conv_clk_o=1, rd_o=1, cs_o=all 1s, fifo_wr_en_o=0, fifo_data_o=0, all counters 0, state IDLE, period counter 0.
- busy_i passes a 2-flop synchroniser; all BUSY decisions use the synchronised value (2-cycle latency).
- Period counter free-runs 0..CONV_PERIOD-1 while en_i=1; held at 0 when en_i=0. Tick at count 0.
- States: IDLE -> CONV (on tick, en_i=1) -> WAIT_RISE -> WAIT_FALL -> HEADER -> RD_L -> RD_H -> (next word/device) -> IDLE.
- CONV: conv_clk_o low for exactly CONV_LOW cycles, then high.
- WAIT_RISE/WAIT_FALL: wait for sync BUSY high then low. Timeout counter starts at CONV entry; reaching BUSY_TIMEOUT -> IDLE, err_cnt_o+1, no FIFO writes.
- HEADER: if fifo_full_i=1, frame skipped: drop_cnt_o+1, IDLE, no reads. Else write {HDR_TAG, frame_cnt_o[7:0]} (fifo_wr_en_o 1 cycle).
- Readout: device index d = 0..N_ADC-1, cs_o[d]=0 for whole device readout, 1 cycle setup before first rd_o fall, 1 cycle hold after last rd_o rise; rd_o low RD_LOW cycles, high RD_HIGH. db_i captured on last RD_LOW cycle; written to FIFO the next cycle unless fifo_full_i=1 that cycle (word dropped, drop_cnt_o+1, readout continues).
- Frame = 1 + N_ADC*CHANNELS words; frame_cnt_o+1 on return to IDLE after last word, regardless of drops.
- Overrun: tick while not IDLE -> that conversion skipped, err_cnt_o+1, current readout completes.
- en_i=0 mid-frame: current frame completes, no new CONV.
- Reset mid-frame: outputs return to reset values immediately (async).
- Word order fixed: device 0 ch0..CHANNELS-1, then device 1, ...

Test Plan:
- Defaults, en_i=1, BUSY model high 100 cycles after CONVST, db_i = 16'h1000+16*dev+ch -> 17 writes per frame: 16'hA500, 16'h1000..16'h1007, 16'h1010..16'h1017; frame_cnt_o=1; conv_clk_o low exactly 4 cycles.
- Check per-device cs_o window and rd_o timing: rd_o low 3, high 2, one cs_o low at a time, cs_o[1] never low during device 0 reads.
- fifo_full_i=1 at HEADER -> no writes, drop_cnt_o=1, next frame header 16'hA500 (frame_cnt unchanged); full for 2 data cycles mid-frame -> 15 writes, drop_cnt_o=2, frame_cnt_o+1.
- BUSY never rises -> after 800 cycles err_cnt_o=1, state IDLE, no writes; next period converts normally.
- CONV_PERIOD=200 with readout longer than period -> err_cnt_o increments each skipped tick, no overlapping frames.
- Assert reset_i mid-readout -> same cycle cs_o=all 1s, rd_o=1, counters 0; 256 frames -> frame_cnt_o=256, header low byte wraps to 8'h00.
